// File: rtl/wm_pkg.sv
// wm_pkg: FSM state encoding and wash-mode constants shared by the panel controller and the washer
package wm_pkg;
  typedef enum logic [1:0] {ST_SELECT, ST_RUN, ST_PAUSE, ST_DONE} state_e;
  typedef enum logic [1:0] {MODE_QUICK, MODE_NORMAL, MODE_HEAVY, MODE_DELICATE} mode_e;
endpackage

// File: rtl/wm_debounce.sv
// wm_debounce: clk/rst, raw_i async input -> out_o (PULSE=1: one-cycle press pulse on clean rise, PULSE=0: clean level)
module wm_debounce #(
  parameter int DB_CYCLES = 4,
  parameter bit PULSE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic out_o
);
  localparam int CW = $clog2(DB_CYCLES) + 1;
  logic s1_q, s2_q, clean_q, prev_q, pulse_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_q, s2_q, clean_q, prev_q, pulse_q} <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      prev_q <= clean_q;
      pulse_q <= clean_q & ~prev_q;
      if (s2_q == clean_q) cnt_q <= '0;
      else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        clean_q <= s2_q;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign out_o = PULSE ? pulse_q : clean_q;
endmodule

// File: rtl/wm_panel_ctrl.sv
// wm_panel_ctrl: raw buttons/door + cycle_done_i -> washer mode_o, start_o, wm_rst_o pulse, busy_o, done_led_o
module wm_panel_ctrl
  import wm_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_i,
  input  logic       btn_start_i,
  input  logic       btn_cancel_i,
  input  logic       door_closed_i,
  input  logic       cycle_done_i,
  output logic [1:0] mode_o,
  output logic       start_o,
  output logic       wm_rst_o,
  output logic       busy_o,
  output logic       done_led_o
);
  logic mode_p, start_p, cancel_p, door;
  logic wm_rst_d;
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  wm_debounce #(.DB_CYCLES(DB_CYCLES), .PULSE(1'b1)) u_mode   (.clk(clk), .rst(rst), .raw_i(btn_mode_i),    .out_o(mode_p));
  wm_debounce #(.DB_CYCLES(DB_CYCLES), .PULSE(1'b1)) u_start  (.clk(clk), .rst(rst), .raw_i(btn_start_i),   .out_o(start_p));
  wm_debounce #(.DB_CYCLES(DB_CYCLES), .PULSE(1'b1)) u_cancel (.clk(clk), .rst(rst), .raw_i(btn_cancel_i),  .out_o(cancel_p));
  wm_debounce #(.DB_CYCLES(DB_CYCLES), .PULSE(1'b0)) u_door   (.clk(clk), .rst(rst), .raw_i(door_closed_i), .out_o(door));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SELECT;
      mode_q <= MODE_QUICK;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    wm_rst_d = 1'b0;
    case (state_q)
      ST_SELECT:
        if (start_p && door) begin
          state_d = ST_RUN;
          wm_rst_d = 1'b1;
        end else if (mode_p) mode_d = mode_e'(mode_q + 2'd1);
      ST_RUN:
        if (cancel_p) begin
          state_d = ST_SELECT;
          wm_rst_d = 1'b1;
        end else if (!door) state_d = ST_PAUSE;
        else if (cycle_done_i) state_d = ST_DONE;
      ST_PAUSE:
        if (cancel_p) begin
          state_d = ST_SELECT;
          wm_rst_d = 1'b1;
        end else if (start_p && door) state_d = ST_RUN;
      ST_DONE:
        if (mode_p || start_p || cancel_p) state_d = ST_SELECT;
      default: state_d = ST_SELECT;
    endcase
  end
  assign wm_rst_o = wm_rst_d & ~rst;
  assign mode_o = mode_q;
  assign start_o = state_q == ST_RUN;
  assign busy_o = state_q == ST_RUN || state_q == ST_PAUSE;
  assign done_led_o = state_q == ST_DONE;
endmodule

// File: tb/tb_wm_panel_ctrl.sv
// tb_wm_panel_ctrl: table-driven and hand-sequenced self-checking bench for wm_panel_ctrl
module tb_wm_panel_ctrl;
  typedef struct {
    logic [2:0] btn;
    int         hold;
    logic       door;
    logic       cd;
    logic [4:0] exp;
    int         nrst;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic btn_mode = 1'b0, btn_start = 1'b0, btn_cancel = 1'b0, door = 1'b0, cdone = 1'b0;
  logic [1:0] mode;
  logic start, wm_rst, busy, done_led;
  int errors = 0, checks = 0, rst_cnt = 0, done_cnt = 0;
  vec_t vecs[21];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  wm_panel_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_mode_i(btn_mode), .btn_start_i(btn_start),
    .btn_cancel_i(btn_cancel), .door_closed_i(door), .cycle_done_i(cdone),
    .mode_o(mode), .start_o(start), .wm_rst_o(wm_rst), .busy_o(busy), .done_led_o(done_led)
  );
  always @(negedge clk) begin
    if (wm_rst) rst_cnt++;
    if (done_led) done_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  function automatic vec_t mk(logic [2:0] b, int h, logic d, logic c, logic [1:0] m, logic [2:0] sbd, int n);
    vec_t v;
    v.btn = b;
    v.hold = h;
    v.door = d;
    v.cd = c;
    v.exp = {m, sbd};
    v.nrst = n;
    return v;
  endfunction
  task automatic apply(vec_t v, string nm);
    int base;
    vec_t e;
    exp_q.push_back(v);
    base = rst_cnt;
    door = v.door;
    repeat (8) tick();
    if (v.cd) begin
      cdone = 1'b1;
      tick();
      cdone = 1'b0;
    end
    {btn_cancel, btn_start, btn_mode} = v.btn;
    repeat (v.hold) tick();
    {btn_cancel, btn_start, btn_mode} = 3'b000;
    repeat (12) tick();
    e = exp_q.pop_front();
    chk({nm, " outs"}, int'({mode, start, busy, done_led}), int'(e.exp));
    chk({nm, " wm_rst"}, rst_cnt - base, e.nrst);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, base;
    // btn bits {cancel,start,mode}; expected {mode,start,busy,done}
    vecs[0]  = mk(3'b001, 10, 1'b0, 1'b0, 2'd1, 3'b000, 0);
    vecs[1]  = mk(3'b001, 10, 1'b0, 1'b0, 2'd2, 3'b000, 0);
    vecs[2]  = mk(3'b001, 10, 1'b0, 1'b0, 2'd3, 3'b000, 0);
    vecs[3]  = mk(3'b001, 10, 1'b0, 1'b0, 2'd0, 3'b000, 0);
    vecs[4]  = mk(3'b001, 10, 1'b0, 1'b0, 2'd1, 3'b000, 0);
    vecs[5]  = mk(3'b001,  2, 1'b0, 1'b0, 2'd1, 3'b000, 0);
    vecs[6]  = mk(3'b001, 10, 1'b0, 1'b0, 2'd2, 3'b000, 0);
    vecs[7]  = mk(3'b010, 10, 1'b0, 1'b0, 2'd2, 3'b000, 0);
    vecs[8]  = mk(3'b010, 10, 1'b1, 1'b0, 2'd2, 3'b110, 1);
    vecs[9]  = mk(3'b001, 10, 1'b1, 1'b0, 2'd2, 3'b110, 0);
    vecs[10] = mk(3'b000,  0, 1'b0, 1'b0, 2'd2, 3'b010, 0);
    vecs[11] = mk(3'b010, 10, 1'b0, 1'b0, 2'd2, 3'b010, 0);
    vecs[12] = mk(3'b010, 10, 1'b1, 1'b0, 2'd2, 3'b110, 0);
    vecs[13] = mk(3'b000,  0, 1'b1, 1'b1, 2'd2, 3'b001, 0);
    vecs[14] = mk(3'b001, 10, 1'b1, 1'b0, 2'd2, 3'b000, 0);
    vecs[15] = mk(3'b100, 10, 1'b1, 1'b0, 2'd2, 3'b000, 0);
    vecs[16] = mk(3'b010, 10, 1'b1, 1'b0, 2'd2, 3'b110, 1);
    vecs[17] = mk(3'b100, 10, 1'b1, 1'b0, 2'd2, 3'b000, 1);
    vecs[18] = mk(3'b010,  3, 1'b1, 1'b0, 2'd2, 3'b000, 0);
    vecs[19] = mk(3'b010, 10, 1'b1, 1'b0, 2'd2, 3'b110, 1);
    vecs[20] = mk(3'b100, 10, 1'b1, 1'b0, 2'd2, 3'b000, 1);
    repeat (3) tick();
    chk("reset outs", int'({mode, start, wm_rst, busy, done_led}), 0);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) apply(vecs[i], $sformatf("vec%0d", i));
    btn_start = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (wm_rst) n = i;
    end
    chk("start latency", n, 7);
    chk("start not yet", int'(start), 0);
    tick();
    chk("start next cycle", int'({wm_rst, start, busy, mode}), int'({3'b011, 2'd2}));
    btn_start = 1'b0;
    apply(mk(3'b001, 10, 1'b1, 1'b0, 2'd2, 3'b110, 0), "run mode held");
    base = rst_cnt;
    rst = 1'b1;
    #1;
    chk("rst no wm_rst", int'(wm_rst), 0);
    tick();
    rst = 1'b0;
    chk("after rst", int'({mode, start, busy, done_led}), 0);
    repeat (3) tick();
    chk("rst wm_rst count", rst_cnt - base, 0);
    apply(mk(3'b010, 10, 1'b1, 1'b0, 2'd0, 3'b110, 1), "rerun");
    base = done_cnt;
    btn_cancel = 1'b1;
    repeat (7) tick();
    cdone = 1'b1;
    #1;
    chk("cancel+done wm_rst", int'(wm_rst), 1);
    tick();
    cdone = 1'b0;
    chk("cancel+done state", int'({start, busy, done_led}), 0);
    btn_cancel = 1'b0;
    repeat (12) tick();
    chk("cancel+done no led", done_cnt - base, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wm_panel_ctrl.md
WM_PANEL_CTRL -- requirements
Module: wm_panel_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4: number of consecutive stable clocks required to accept a button or door level change.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 btn_mode  input  1  raw mode-select button, active-high, asynchronous to clk.
REQ-005 btn_start  input  1  raw start button, active-high, asynchronous.
REQ-006 btn_cancel  input  1  raw cancel button, active-high, asynchronous.
REQ-007 door_closed  input  1  raw door interlock switch; 1 = closed.
REQ-008 cycle_done  input  1  washer completion flag (washer "out"); level, synchronous to clk.
REQ-009 mode  output  2  selected wash mode driven to the washer: 0 QUICK, 1 NORMAL, 2 HEAVY, 3 DELICATE.
REQ-010 start  output  1  washer start level; high only in RUN.
REQ-011 wm_rst  output  1  one-cycle synchronous reset pulse to the washer.
REQ-012 busy  output  1  high in RUN and PAUSE.
REQ-013 done_led  output  1  high in DONE.

Function
REQ-014 Each raw input shall pass through a 2-flop synchroniser, then a debouncer that updates its clean level only after DB_CYCLES consecutive identical synchronised samples.
REQ-015 For buttons, a 1-cycle press pulse shall fire on the clean 0->1 transition; for a raw input rising at sampled cycle N and held stable, the pulse shall occur at cycle N+2+DB_CYCLES.
REQ-016 Glitches shorter than DB_CYCLES clocks shall produce no pulse and no level change.
REQ-017 FSM states: SELECT, RUN, PAUSE, DONE.
REQ-018 SELECT: a mode pulse shall advance mode by 1 modulo 4 (3 -> 0 wraps); start, busy, done_led = 0.
REQ-019 SELECT -> RUN on a start pulse only when clean door_closed = 1; the transition cycle shall assert wm_rst for exactly one cycle, and start shall rise in the following cycle.
REQ-020 Start pulse with door open shall be ignored; state and mode unchanged.
REQ-021 RUN: mode held constant; mode pulses ignored; start = 1.
REQ-022 RUN -> PAUSE when clean door_closed falls; start = 0 in PAUSE, busy stays 1, no wm_rst.
REQ-023 PAUSE -> RUN on a start pulse with door closed; no wm_rst on resume.
REQ-024 RUN -> DONE when cycle_done = 1 (sampled directly, no debounce); start drops the next cycle.
REQ-025 DONE -> SELECT on any button pulse (mode, start or cancel); that pulse is consumed and shall not also change mode or start a cycle.
REQ-026 Cancel pulse in RUN or PAUSE -> SELECT, asserting wm_rst for one cycle; mode retained.
REQ-027 Priority within one cycle: cancel > door-open > cycle_done > start > mode.
REQ-028 cycle_done in PAUSE shall be ignored.

Reset
REQ-029 On rst = 1: state = SELECT, mode = 0, start = 0, wm_rst = 0, busy = 0, done_led = 0; synchroniser and debouncer clean levels = 0, counters = 0.
REQ-030 rst mid-RUN shall drop start in the next cycle and shall not generate wm_rst.

Structure
REQ-031 Package wm_pkg shall hold the FSM state encoding and the four mode constants, shared with the washer.
REQ-032 Sub-module wm_debounce (sync + debounce + edge pulse, DB_CYCLES parameter) shall be instantiated four times.

Verification
REQ-033 DB_CYCLES = 4, btn_mode pulse held 10 clks, repeated 5 times -> mode sequence 1, 2, 3, 0, 1.
REQ-034 btn_mode glitch of 2 clks -> no pulse; mode unchanged.
REQ-035 Door closed, mode = 2, btn_start held -> wm_rst high for exactly 1 cycle at cycle N+6, start = 1 from N+7, mode stays 2 despite later mode presses.
REQ-036 In RUN, door opened for 10 clks then start pressed -> start = 0 and busy = 1 during PAUSE, then start = 1 again with no wm_rst.
REQ-037 In RUN, cycle_done = 1 -> done_led = 1 and start = 0 next cycle; a btn_mode press -> SELECT with mode unchanged.
REQ-038 In RUN, btn_cancel and cycle_done in the same cycle -> SELECT with a 1-cycle wm_rst, done_led never asserted.
